decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Parametrised successor decode stage for the RV32 pipeline, sitting between fetch and execute.
- Decodes the fetched instruction into class flags, fields and immediate.
- Owns the integer register file: XLEN-bit entries, synchronous write from writeback.
- Resolves RAW hazards against NUM_BYPASS downstream channels, using forwarding or stalling.
- Issues into execute through a registered valid/ready output stage with bubble insertion and flush.

Parameters:
- XLEN, 32, register/data width.
- ILEN, 32, instruction width.
- REG_FILE_LEN, 32, number of architectural registers; index width RW = $clog2(REG_FILE_LEN).
- NUM_BYPASS, 2, number of forwarding channels. Index 0 is the youngest (exe), ascending is older (mem, ...).
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- inst_in  in  ILEN  fetched instruction
- inst_valid_in  in  1  inst_in valid
- stall_dec_out  out  1  decode cannot accept inst_in this cycle; fetch holds
- flush_in  in  1  kill the instruction in decode and the output register
- byp_valid_in  in  NUM_BYPASS  channel holds a valid instruction
- byp_we_in  in  NUM_BYPASS  channel writes a register
- byp_rd_in  in  NUM_BYPASS*RW  channel destination, flattened, channel 0 in LSBs
- byp_data_in  in  NUM_BYPASS*XLEN  channel result, flattened
- byp_pending_in  in  NUM_BYPASS  channel result not yet available (load in flight)
- wb_valid_in  in  1  writeback valid
- wb_we_in  in  1  writeback register write
- wb_rd_in  in  RW  writeback destination
- wb_data_in  in  XLEN  writeback data
- dec_valid_out  out  1  output register valid
- dec_ready_in  in  1  execute accepts the output
- dec_is_reg_reg/is_imm/is_load/is_store/is_branch/is_lui/is_sys/is_mul_out  out  1 each  class flags
- dec_rs1_data_out, dec_rs2_data_out  out  XLEN  resolved operands
- dec_rd_out  out  RW  destination
- dec_we_out  out  1  instruction writes rd, and rd != 0
- dec_imm_out  out  XLEN  sign-extended immediate (I/S/B/U/J per opcode)
- dec_funct3_out  out  3  funct3 field
- dec_funct7_out  out  7  funct7 field
- stall_cnt_out  out  PERF_W  hazard stall cycles

Behaviour:
- Reset (rst=0, async): all outputs 0, register file cleared, stall_cnt_out=0.
- Decode, combinational on inst_in. Opcode = inst_in[6:0].
  - 0x33: reg_reg; is_mul additionally requires funct7=0x01.
  - 0x13: imm. 0x03: load. 0x23: store. 0x63: branch. 0x37/0x17: lui. 0x73: sys.
  - Unknown opcode: all flags 0, we=0 (passes as a NOP).
- Source usage:
  - rs1 used by all classes except lui/J.
  - rs2 used only by reg_reg, store and branch.
  - Register 0 is never a dependency and always reads 0.
- Operand resolution, per used source, first match wins:
  1. lowest-index bypass channel with valid & we & rd==src;
  2. writeback with wb_valid & wb_we & wb_rd==src (write-through);
  3. register file.
- Hazard: the winning match is a bypass channel with byp_pending_in=1. A load-use hit on an older channel is shadowed by a younger non-pending hit.
- Issue condition: can_load = ~dec_valid_out | dec_ready_in.
- stall_dec_out = inst_valid_in & (hazard | ~can_load).
- Output register update on clk when can_load:
  - if inst_valid_in & ~hazard & ~flush_in: load the decoded fields, dec_valid_out=1;
  - otherwise dec_valid_out=0 (bubble). Data fields are don't-care.
- When ~can_load the output register holds every field stable (valid/ready rule: no change while valid & ~ready).
- flush_in: dec_valid_out cleared next edge regardless of dec_ready_in; stall_dec_out forced 0 that cycle.
- Register file: written on clk when wb_valid & wb_we & wb_rd!=0. Write to x0 ignored.
- stall_cnt_out increments on each cycle with inst_valid_in & hazard & ~flush_in. It saturates at all-ones and does not wrap.
- Simultaneous writeback and read of the same register returns wb_data_in.

Optional Feature:
- DECODE_FWD_EN defined: forwarding as above; only pending matches stall.
- Undefined: no bypass data used. Any source matching a valid writing bypass channel is a hazard. Operands come only from writeback write-through or the register file; byp_data_in is ignored.

Test Plan:
- After reset, write x5=0x1234 via writeback; next, issue ADD x6,x5,x0 (0x00028333) with dec_ready_in=1 -> dec_valid_out=1 next cycle, rs1_data=0x1234, rs2_data=0, is_reg_reg=1, we=1, rd=6.
- ch0 rd=5 data=0xAAAA and ch1 rd=5 data=0xBBBB, both valid/we, decode ADDI x7,x5,-1 -> rs1_data=0xAAAA, imm=0xFFFFFFFF. Without DECODE_FWD_EN: stall_dec_out=1 and a bubble is issued.
- ch0 rd=5 pending=1, decode uses x5 -> stall_dec_out=1 and a bubble each cycle, stall_cnt_out increments. Drop pending and present data 0x55 -> issue with rs1_data=0x55.
- dec_valid_out=1, dec_ready_in=0 for 3 cycles with a new inst_valid_in -> outputs stable, stall_dec_out=1. ready=1 -> next instruction loaded.
- flush_in with dec_valid_out=1, dec_ready_in=0 -> dec_valid_out=0 next edge. Writeback to x0 with 0xFFFF -> x0 still reads 0.
- Assert rst low mid-stall -> all outputs 0 immediately and stall_cnt_out=0. Force stall_cnt to all-ones -> further stall cycles keep it at all-ones.

Source files
------------

// File: rtl/decode_issue_stage.sv
// RV32 decode/issue stage: instruction decode, integer register file, RAW hazard resolution
// against downstream bypass channels and a registered valid/ready issue stage.
// Build option: define DECODE_FWD_EN to forward bypass results instead of stalling on every bypass match.
module decode_issue_stage #(
    parameter int XLEN         = 32,
    parameter int ILEN         = 32,
    parameter int REG_FILE_LEN = 32,
    parameter int NUM_BYPASS   = 2,
    parameter int PERF_W       = 32,
    localparam int RW          = $clog2(REG_FILE_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ILEN-1:0]            inst_in,
    input  logic                       inst_valid_in,
    output logic                       stall_dec_out,
    input  logic                       flush_in,
    input  logic [NUM_BYPASS-1:0]      byp_valid_in,
    input  logic [NUM_BYPASS-1:0]      byp_we_in,
    input  logic [NUM_BYPASS*RW-1:0]   byp_rd_in,
    input  logic [NUM_BYPASS*XLEN-1:0] byp_data_in,
    input  logic [NUM_BYPASS-1:0]      byp_pending_in,
    input  logic                       wb_valid_in,
    input  logic                       wb_we_in,
    input  logic [RW-1:0]              wb_rd_in,
    input  logic [XLEN-1:0]            wb_data_in,
    output logic                       dec_valid_out,
    input  logic                       dec_ready_in,
    output logic                       dec_is_reg_reg_out,
    output logic                       dec_is_imm_out,
    output logic                       dec_is_load_out,
    output logic                       dec_is_store_out,
    output logic                       dec_is_branch_out,
    output logic                       dec_is_lui_out,
    output logic                       dec_is_sys_out,
    output logic                       dec_is_mul_out,
    output logic [XLEN-1:0]            dec_rs1_data_out,
    output logic [XLEN-1:0]            dec_rs2_data_out,
    output logic [RW-1:0]              dec_rd_out,
    output logic                       dec_we_out,
    output logic [XLEN-1:0]            dec_imm_out,
    output logic [2:0]                 dec_funct3_out,
    output logic [6:0]                 dec_funct7_out,
    output logic [PERF_W-1:0]          stall_cnt_out
);

    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYS    = 7'h73;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    logic [6:0]      w_opcode;
    logic [RW-1:0]   w_rd;
    logic [RW-1:0]   w_rs1;
    logic [RW-1:0]   w_rs2;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_is_reg_reg;
    logic            w_is_imm;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic            w_is_lui;
    logic            w_is_sys;
    logic            w_is_mul;
    logic            w_writes;
    logic            w_we;
    logic [XLEN-1:0] w_imm;
    logic [RW-1:0]   w_src     [2];
    logic            w_use     [2];
    logic [XLEN-1:0] w_opnd    [2];
    logic            w_src_haz [2];
    logic            w_hazard;
    logic            w_can_load;
    logic            w_issue;

    logic [XLEN-1:0]   r_rf [REG_FILE_LEN];
    logic              r_valid;
    logic              r_is_reg_reg;
    logic              r_is_imm;
    logic              r_is_load;
    logic              r_is_store;
    logic              r_is_branch;
    logic              r_is_lui;
    logic              r_is_sys;
    logic              r_is_mul;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [RW-1:0]     r_rd;
    logic              r_we;
    logic [XLEN-1:0]   r_imm;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [PERF_W-1:0] r_stall_cnt;

    assign w_opcode = inst_in[6:0];
    assign w_rd     = inst_in[7 +: RW];
    assign w_funct3 = inst_in[14:12];
    assign w_rs1    = inst_in[15 +: RW];
    assign w_rs2    = inst_in[20 +: RW];
    assign w_funct7 = inst_in[31:25];

    // Opcode decode: class flags, source usage and the per-format sign-extended immediate
    always_comb begin
        w_is_reg_reg = 1'b0;
        w_is_imm     = 1'b0;
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_is_branch  = 1'b0;
        w_is_lui     = 1'b0;
        w_is_sys     = 1'b0;
        w_writes     = 1'b0;
        w_use[0]     = 1'b0;
        w_use[1]     = 1'b0;
        w_imm        = {XLEN{1'b0}};
        case (w_opcode)
            OP_REG: begin
                w_is_reg_reg = 1'b1;
                w_writes     = 1'b1;
                w_use[0]     = 1'b1;
                w_use[1]     = 1'b1;
            end
            OP_IMM: begin
                w_is_imm = 1'b1;
                w_writes = 1'b1;
                w_use[0] = 1'b1;
                w_imm    = XLEN'($signed(inst_in[31:20]));
            end
            OP_LOAD: begin
                w_is_load = 1'b1;
                w_writes  = 1'b1;
                w_use[0]  = 1'b1;
                w_imm     = XLEN'($signed(inst_in[31:20]));
            end
            OP_STORE: begin
                w_is_store = 1'b1;
                w_use[0]   = 1'b1;
                w_use[1]   = 1'b1;
                w_imm      = XLEN'($signed({inst_in[31:25], inst_in[11:7]}));
            end
            OP_BRANCH: begin
                w_is_branch = 1'b1;
                w_use[0]    = 1'b1;
                w_use[1]    = 1'b1;
                w_imm       = XLEN'($signed({inst_in[31], inst_in[7], inst_in[30:25],
                                             inst_in[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                w_is_lui = 1'b1;
                w_writes = 1'b1;
                w_imm    = XLEN'($signed({inst_in[31:12], 12'h000}));
            end
            OP_SYS: begin
                w_is_sys = 1'b1;
                w_writes = 1'b1;
                w_use[0] = 1'b1;
                w_imm    = XLEN'($signed(inst_in[31:20]));
            end
            // Jumps are not an issued class here: immediate only, no flags, no sources
            OP_JAL: begin
                w_imm = XLEN'($signed({inst_in[31], inst_in[19:12], inst_in[20],
                                       inst_in[30:21], 1'b0}));
            end
            OP_JALR: begin
                w_imm = XLEN'($signed(inst_in[31:20]));
            end
            default: begin
                w_imm = {XLEN{1'b0}};
            end
        endcase
    end

    assign w_is_mul  = w_is_reg_reg & (w_funct7 == 7'h01);
    assign w_we      = w_writes & (w_rd != {RW{1'b0}});
    assign w_src[0]  = w_rs1;
    assign w_src[1]  = w_rs2;

    // Operand resolution: youngest matching bypass, then writeback write-through, then register file
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_opnd[s]    = {XLEN{1'b0}};
            w_src_haz[s] = 1'b0;
            if (w_use[s] && (w_src[s] != {RW{1'b0}})) begin
                if (wb_valid_in && wb_we_in && (wb_rd_in == w_src[s])) begin
                    w_opnd[s] = wb_data_in;
                end else begin
                    w_opnd[s] = r_rf[w_src[s]];
                end
                // Walk oldest to youngest so the lowest-index hit is the one left standing
                for (int c = NUM_BYPASS - 1; c >= 0; c--) begin
                    if (byp_valid_in[c] && byp_we_in[c] && (byp_rd_in[c*RW +: RW] == w_src[s])) begin
`ifdef DECODE_FWD_EN
                        w_opnd[s]    = byp_data_in[c*XLEN +: XLEN];
                        w_src_haz[s] = byp_pending_in[c];
`else
                        w_src_haz[s] = 1'b1;
`endif
                    end else begin
                        w_src_haz[s] = w_src_haz[s];
                    end
                end
            end else begin
                w_opnd[s]    = {XLEN{1'b0}};
                w_src_haz[s] = 1'b0;
            end
        end
    end

`ifndef DECODE_FWD_EN
    logic w_unused_byp;
    assign w_unused_byp = ^{byp_data_in, byp_pending_in};
`endif

    assign w_hazard   = inst_valid_in & (w_src_haz[0] | w_src_haz[1]);
    assign w_can_load = ~r_valid | dec_ready_in;
    assign w_issue    = inst_valid_in & ~w_hazard & ~flush_in;
    // Reset is folded in so the stall request reads 0 while the stage is held in reset
    assign stall_dec_out = rst & inst_valid_in & ~flush_in & (w_hazard | ~w_can_load);

    // Register file write port; x0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_FILE_LEN; i++) begin
                r_rf[i] <= {XLEN{1'b0}};
            end
        end else if (wb_valid_in && wb_we_in && (wb_rd_in != {RW{1'b0}})) begin
            r_rf[wb_rd_in] <= wb_data_in;
        end
    end

    // Issue register: loads on a free slot, holds under backpressure, flush always drops valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_is_reg_reg <= 1'b0;
            r_is_imm     <= 1'b0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_is_branch  <= 1'b0;
            r_is_lui     <= 1'b0;
            r_is_sys     <= 1'b0;
            r_is_mul     <= 1'b0;
            r_rs1_data   <= {XLEN{1'b0}};
            r_rs2_data   <= {XLEN{1'b0}};
            r_rd         <= {RW{1'b0}};
            r_we         <= 1'b0;
            r_imm        <= {XLEN{1'b0}};
            r_funct3     <= 3'b000;
            r_funct7     <= 7'h00;
        end else if (w_can_load) begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_is_reg_reg <= w_is_reg_reg;
                r_is_imm     <= w_is_imm;
                r_is_load    <= w_is_load;
                r_is_store   <= w_is_store;
                r_is_branch  <= w_is_branch;
                r_is_lui     <= w_is_lui;
                r_is_sys     <= w_is_sys;
                r_is_mul     <= w_is_mul;
                r_rs1_data   <= w_opnd[0];
                r_rs2_data   <= w_opnd[1];
                r_rd         <= w_rd;
                r_we         <= w_we;
                r_imm        <= w_imm;
                r_funct3     <= w_funct3;
                r_funct7     <= w_funct7;
            end
        end else if (flush_in) begin
            r_valid <= 1'b0;
        end
    end

    // Hazard stall counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= {PERF_W{1'b0}};
        end else if (w_hazard && !flush_in && (r_stall_cnt != {PERF_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign dec_valid_out      = r_valid;
    assign dec_is_reg_reg_out = r_is_reg_reg;
    assign dec_is_imm_out     = r_is_imm;
    assign dec_is_load_out    = r_is_load;
    assign dec_is_store_out   = r_is_store;
    assign dec_is_branch_out  = r_is_branch;
    assign dec_is_lui_out     = r_is_lui;
    assign dec_is_sys_out     = r_is_sys;
    assign dec_is_mul_out     = r_is_mul;
    assign dec_rs1_data_out   = r_rs1_data;
    assign dec_rs2_data_out   = r_rs2_data;
    assign dec_rd_out         = r_rd;
    assign dec_we_out         = r_we;
    assign dec_imm_out        = r_imm;
    assign dec_funct3_out     = r_funct3;
    assign dec_funct7_out     = r_funct7;
    assign stall_cnt_out      = r_stall_cnt;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage; expectations follow the DECODE_FWD_EN build setting.
module tb_decode_issue_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int NB   = 2;
    localparam int PW   = 4;

    localparam logic [31:0] I_ADD   = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] I_MUL   = 32'h026284B3; // mul  x9,x5,x6
    localparam logic [31:0] I_ADDI7 = 32'hFFF28393; // addi x7,x5,-1
    localparam logic [31:0] I_ADDI8 = 32'h00128413; // addi x8,x5,1
    localparam logic [31:0] I_LUI   = 32'h12345537; // lui  x10,0x12345
    localparam logic [31:0] I_SW    = 32'h0062A423; // sw   x6,8(x5)
    localparam logic [31:0] I_ADD0  = 32'h000005B3; // add  x11,x0,x0
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3; // beq  x0,x0,-4
    localparam logic [31:0] I_JAL   = 32'h000000EF; // jal  x1,0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, inst_valid_in, stall_dec_out, flush_in;
    logic [31:0]      inst_in;
    logic [NB-1:0]    byp_valid_in, byp_we_in, byp_pending_in;
    logic [NB*RW-1:0] byp_rd_in;
    logic [NB*XLEN-1:0] byp_data_in;
    logic             wb_valid_in, wb_we_in, dec_valid_out, dec_ready_in;
    logic [RW-1:0]    wb_rd_in, dec_rd_out;
    logic [XLEN-1:0]  wb_data_in, dec_rs1_data_out, dec_rs2_data_out, dec_imm_out;
    logic             dec_is_reg_reg_out, dec_is_imm_out, dec_is_load_out, dec_is_store_out;
    logic             dec_is_branch_out, dec_is_lui_out, dec_is_sys_out, dec_is_mul_out, dec_we_out;
    logic [2:0]       dec_funct3_out;
    logic [6:0]       dec_funct7_out;
    logic [PW-1:0]    stall_cnt_out;
    logic [7:0]       flags;

    int total = 0;
    int bad = 0;
    logic [PW-1:0] exp_cnt = 4'd0;

    assign flags = {dec_is_reg_reg_out, dec_is_imm_out, dec_is_load_out, dec_is_store_out,
                    dec_is_branch_out, dec_is_lui_out, dec_is_sys_out, dec_is_mul_out};

    decode_issue_stage #(.XLEN(XLEN), .ILEN(32), .REG_FILE_LEN(32), .NUM_BYPASS(NB), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid_in(inst_valid_in),
        .stall_dec_out(stall_dec_out), .flush_in(flush_in),
        .byp_valid_in(byp_valid_in), .byp_we_in(byp_we_in), .byp_rd_in(byp_rd_in),
        .byp_data_in(byp_data_in), .byp_pending_in(byp_pending_in),
        .wb_valid_in(wb_valid_in), .wb_we_in(wb_we_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
        .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in),
        .dec_is_reg_reg_out(dec_is_reg_reg_out), .dec_is_imm_out(dec_is_imm_out),
        .dec_is_load_out(dec_is_load_out), .dec_is_store_out(dec_is_store_out),
        .dec_is_branch_out(dec_is_branch_out), .dec_is_lui_out(dec_is_lui_out),
        .dec_is_sys_out(dec_is_sys_out), .dec_is_mul_out(dec_is_mul_out),
        .dec_rs1_data_out(dec_rs1_data_out), .dec_rs2_data_out(dec_rs2_data_out),
        .dec_rd_out(dec_rd_out), .dec_we_out(dec_we_out), .dec_imm_out(dec_imm_out),
        .dec_funct3_out(dec_funct3_out), .dec_funct7_out(dec_funct7_out),
        .stall_cnt_out(stall_cnt_out)
    );

    task automatic idle();
        rst = 1'b1; inst_in = 32'h0; inst_valid_in = 1'b0; flush_in = 1'b0; dec_ready_in = 1'b1;
        byp_valid_in = 2'b00; byp_we_in = 2'b00; byp_rd_in = 10'h0; byp_data_in = 64'h0;
        byp_pending_in = 2'b00; wb_valid_in = 1'b0; wb_we_in = 1'b0; wb_rd_in = 5'd0; wb_data_in = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b0; inst_in = I_ADD; inst_valid_in = 1'b1; #2;
        total++; if ({dec_valid_out, flags, dec_we_out, stall_dec_out} !== 11'h0) begin
            bad++; $display("FAIL reset_ctl got=%h exp=0", {dec_valid_out, flags, dec_we_out, stall_dec_out}); end
        total++; if ({stall_cnt_out, dec_rs1_data_out, dec_imm_out} !== 68'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {stall_cnt_out, dec_rs1_data_out, dec_imm_out}); end
        tick(); idle(); tick();
    endtask

    task automatic test_add();
        wb_valid_in = 1'b1; wb_we_in = 1'b1; wb_rd_in = 5'd5; wb_data_in = 32'h1234; tick();
        idle(); inst_in = I_ADD; inst_valid_in = 1'b1; #1;
        total++; if (stall_dec_out !== 1'b0) begin bad++; $display("FAIL add_stall got=%b exp=0", stall_dec_out); end
        tick();
        total++; if ({dec_valid_out, flags} !== 9'h180) begin
            bad++; $display("FAIL add_flags got=%h exp=180", {dec_valid_out, flags}); end
        total++; if ({dec_rs1_data_out, dec_rs2_data_out} !== {32'h1234, 32'h0}) begin
            bad++; $display("FAIL add_ops got=%h exp=%h", {dec_rs1_data_out, dec_rs2_data_out}, {32'h1234, 32'h0}); end
        total++; if ({dec_we_out, dec_rd_out} !== {1'b1, 5'd6}) begin
            bad++; $display("FAIL add_rd got=%h exp=%h", {dec_we_out, dec_rd_out}, {1'b1, 5'd6}); end
        inst_valid_in = 1'b0; tick();
        total++; if (dec_valid_out !== 1'b0) begin bad++; $display("FAIL add_bubble got=%b exp=0", dec_valid_out); end
    endtask

    task automatic test_writethrough();
        idle(); wb_valid_in = 1'b1; wb_we_in = 1'b1; wb_rd_in = 5'd6; wb_data_in = 32'h77;
        inst_in = I_MUL; inst_valid_in = 1'b1; tick();
        total++; if ({dec_valid_out, flags, dec_funct7_out} !== {1'b1, 8'h81, 7'h01}) begin
            bad++; $display("FAIL mul_flags got=%h exp=%h", {dec_valid_out, flags, dec_funct7_out}, {1'b1, 8'h81, 7'h01}); end
        total++; if ({dec_rs1_data_out, dec_rs2_data_out} !== {32'h1234, 32'h77}) begin
            bad++; $display("FAIL mul_wt got=%h exp=%h", {dec_rs1_data_out, dec_rs2_data_out}, {32'h1234, 32'h77}); end
        idle(); tick();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        for (int k = 0; k < 3; k++) begin
            idle(); byp_we_in = 2'b11; byp_rd_in = {5'd5, 5'd5}; byp_data_in = {32'hBBBB, 32'hAAAA};
            case (k)
                0: begin byp_valid_in = 2'b11; byp_pending_in = 2'b00; exp_d = 32'hAAAA; end
                1: begin byp_valid_in = 2'b11; byp_pending_in = 2'b10; exp_d = 32'hAAAA; end
                default: begin byp_valid_in = 2'b10; byp_pending_in = 2'b00; exp_d = 32'hBBBB; end
            endcase
            inst_in = I_ADDI7; inst_valid_in = 1'b1; #1;
`ifdef DECODE_FWD_EN
            total++; if (stall_dec_out !== 1'b0) begin bad++; $display("FAIL byp%0d_stall got=%b exp=0", k, stall_dec_out); end
            tick();
            total++; if ({dec_valid_out, flags, dec_rd_out} !== {1'b1, 8'h40, 5'd7}) begin
                bad++; $display("FAIL byp%0d_flags got=%h exp=%h", k, {dec_valid_out, flags, dec_rd_out}, {1'b1, 8'h40, 5'd7}); end
            total++; if ({dec_rs1_data_out, dec_imm_out} !== {exp_d, 32'hFFFFFFFF}) begin
                bad++; $display("FAIL byp%0d_data got=%h exp=%h", k, {dec_rs1_data_out, dec_imm_out}, {exp_d, 32'hFFFFFFFF}); end
`else
            total++; if (stall_dec_out !== 1'b1) begin bad++; $display("FAIL byp%0d_stall got=%b exp=1", k, stall_dec_out); end
            tick(); bump();
            total++; if ({dec_valid_out, stall_cnt_out} !== {1'b0, exp_cnt}) begin
                bad++; $display("FAIL byp%0d_bubble got=%h exp=%h (data %h unused)", k, {dec_valid_out, stall_cnt_out}, {1'b0, exp_cnt}, exp_d); end
`endif
        end
        idle(); tick();
    endtask

    task automatic test_pending();
        idle(); byp_valid_in = 2'b01; byp_we_in = 2'b01; byp_rd_in = {5'd0, 5'd5}; byp_pending_in = 2'b01;
        inst_in = I_ADDI8; inst_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (stall_dec_out !== 1'b1) begin bad++; $display("FAIL pend%0d_stall got=%b exp=1", k, stall_dec_out); end
            tick(); bump();
            total++; if ({dec_valid_out, stall_cnt_out} !== {1'b0, exp_cnt}) begin
                bad++; $display("FAIL pend%0d_cnt got=%h exp=%h", k, {dec_valid_out, stall_cnt_out}, {1'b0, exp_cnt}); end
        end
        byp_pending_in = 2'b00; byp_data_in = {32'h0, 32'h55}; #1;
`ifdef DECODE_FWD_EN
        total++; if (stall_dec_out !== 1'b0) begin bad++; $display("FAIL pend_release got=%b exp=0", stall_dec_out); end
        tick();
        total++; if ({dec_valid_out, dec_rs1_data_out, dec_imm_out} !== {1'b1, 32'h55, 32'h1}) begin
            bad++; $display("FAIL pend_issue got=%h exp=%h", {dec_valid_out, dec_rs1_data_out, dec_imm_out}, {1'b1, 32'h55, 32'h1}); end
`else
        total++; if (stall_dec_out !== 1'b1) begin bad++; $display("FAIL pend_release got=%b exp=1", stall_dec_out); end
        tick(); bump();
        byp_valid_in = 2'b00; tick();
        total++; if ({dec_valid_out, dec_rs1_data_out, dec_imm_out} !== {1'b1, 32'h1234, 32'h1}) begin
            bad++; $display("FAIL pend_issue got=%h exp=%h", {dec_valid_out, dec_rs1_data_out, dec_imm_out}, {1'b1, 32'h1234, 32'h1}); end
`endif
        idle(); tick();
    endtask

    task automatic test_backpressure();
        idle(); inst_in = I_LUI; inst_valid_in = 1'b1; tick();
        total++; if ({dec_valid_out, flags, dec_imm_out, dec_rd_out} !== {1'b1, 8'h04, 32'h12345000, 5'd10}) begin
            bad++; $display("FAIL lui got=%h exp=%h", {dec_valid_out, flags, dec_imm_out, dec_rd_out}, {1'b1, 8'h04, 32'h12345000, 5'd10}); end
        dec_ready_in = 1'b0; inst_in = I_SW;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (stall_dec_out !== 1'b1) begin bad++; $display("FAIL hold%0d_stall got=%b exp=1", k, stall_dec_out); end
            tick();
            total++; if ({dec_valid_out, flags, dec_imm_out, dec_rd_out, stall_cnt_out} !== {1'b1, 8'h04, 32'h12345000, 5'd10, exp_cnt}) begin
                bad++; $display("FAIL hold%0d_out got=%h exp=%h", k, {dec_valid_out, flags, dec_imm_out, dec_rd_out, stall_cnt_out},
                                {1'b1, 8'h04, 32'h12345000, 5'd10, exp_cnt}); end
        end
        dec_ready_in = 1'b1; #1;
        total++; if (stall_dec_out !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", stall_dec_out); end
        tick();
        total++; if ({dec_valid_out, flags, dec_imm_out, dec_we_out, dec_funct3_out} !== {1'b1, 8'h10, 32'h8, 1'b0, 3'd2}) begin
            bad++; $display("FAIL sw got=%h exp=%h", {dec_valid_out, flags, dec_imm_out, dec_we_out, dec_funct3_out}, {1'b1, 8'h10, 32'h8, 1'b0, 3'd2}); end
        total++; if ({dec_rs1_data_out, dec_rs2_data_out} !== {32'h1234, 32'h77}) begin
            bad++; $display("FAIL sw_ops got=%h exp=%h", {dec_rs1_data_out, dec_rs2_data_out}, {32'h1234, 32'h77}); end
    endtask

    task automatic test_flush_x0();
        idle(); dec_ready_in = 1'b0; flush_in = 1'b1; inst_in = I_ADD; inst_valid_in = 1'b1;
        byp_valid_in = 2'b01; byp_we_in = 2'b01; byp_rd_in = {5'd0, 5'd5}; byp_pending_in = 2'b01; #1;
        total++; if (stall_dec_out !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_dec_out); end
        tick();
        total++; if ({dec_valid_out, stall_cnt_out} !== {1'b0, exp_cnt}) begin
            bad++; $display("FAIL flush_valid got=%h exp=%h", {dec_valid_out, stall_cnt_out}, {1'b0, exp_cnt}); end
        idle(); wb_valid_in = 1'b1; wb_we_in = 1'b1; wb_rd_in = 5'd0; wb_data_in = 32'hFFFF;
        inst_in = I_ADD0; inst_valid_in = 1'b1; tick();
        total++; if ({dec_valid_out, dec_rs1_data_out, dec_rs2_data_out, dec_rd_out} !== {1'b1, 64'h0, 5'd11}) begin
            bad++; $display("FAIL x0_read got=%h exp=%h", {dec_valid_out, dec_rs1_data_out, dec_rs2_data_out, dec_rd_out}, {1'b1, 64'h0, 5'd11}); end
    endtask

    task automatic test_branch_unknown();
        idle(); inst_in = I_BEQ; inst_valid_in = 1'b1; tick();
        total++; if ({dec_valid_out, flags, dec_imm_out, dec_we_out} !== {1'b1, 8'h08, 32'hFFFFFFFC, 1'b0}) begin
            bad++; $display("FAIL beq got=%h exp=%h", {dec_valid_out, flags, dec_imm_out, dec_we_out}, {1'b1, 8'h08, 32'hFFFFFFFC, 1'b0}); end
        inst_in = I_JAL; tick();
        total++; if ({dec_valid_out, flags, dec_we_out} !== {1'b1, 8'h00, 1'b0}) begin
            bad++; $display("FAIL unknown got=%h exp=%h", {dec_valid_out, flags, dec_we_out}, {1'b1, 8'h00, 1'b0}); end
        idle(); tick();
    endtask

    task automatic test_saturate_reset();
        idle(); inst_in = I_LUI; inst_valid_in = 1'b1; tick();
        byp_valid_in = 2'b01; byp_we_in = 2'b01; byp_rd_in = {5'd0, 5'd5}; byp_pending_in = 2'b01;
        inst_in = I_ADDI8;
        for (int k = 0; k < 20; k++) begin
            tick(); bump();
        end
        total++; if (stall_cnt_out !== 4'hF || exp_cnt !== 4'hF) begin
            bad++; $display("FAIL saturate got=%h exp=f", stall_cnt_out); end
        rst = 1'b0; #1;
        total++; if ({dec_valid_out, flags, dec_we_out, stall_dec_out, dec_rd_out} !== 16'h0) begin
            bad++; $display("FAIL midreset_ctl got=%h exp=0", {dec_valid_out, flags, dec_we_out, stall_dec_out, dec_rd_out}); end
        total++; if ({stall_cnt_out, dec_imm_out} !== 36'h0) begin
            bad++; $display("FAIL midreset_data got=%h exp=0", {stall_cnt_out, dec_imm_out}); end
        tick(); exp_cnt = 4'd0;
        idle(); inst_in = I_ADD; inst_valid_in = 1'b1; tick();
        total++; if ({dec_valid_out, dec_rs1_data_out, stall_cnt_out} !== {1'b1, 32'h0, 4'h0}) begin
            bad++; $display("FAIL rf_cleared got=%h exp=%h", {dec_valid_out, dec_rs1_data_out, stall_cnt_out}, {1'b1, 32'h0, 4'h0}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_writethrough();
        test_bypass();
        test_pending();
        test_backpressure();
        test_flush_x0();
        test_branch_unknown();
        test_saturate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
